// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer.
// Replays the solved tour by turning each one-hot knight move into two motion
// commands: a vertical "move" and a horizontal "move with fanfare". In IDLE the
// UART command path passes straight through to the command processor.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start_tour        single-cycle pulse after the solver is done
//   move[7:0]         one-hot knight move for mv_indx (from solver)
//   mv_indx[4:0]      replay index driven to the solver (registered)
//   cmd_UART[15:0]    command from the UART wrapper
//   cmd_rdy_UART      UART command valid
//   clr_cmd_rdy_UART  consume UART command
//   cmd[15:0]         command to the command processor
//   cmd_rdy           command valid to the command processor
//   clr_cmd_rdy       command processor accepted the command
//   send_resp         command processor finished the command
//   resp[7:0]         response byte to the UART
module tour_cmd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned HDG_W  = 8;
  localparam int unsigned SQ_W   = 4;
  localparam int unsigned OPC_W  = 4;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(23);
  localparam logic [OPC_W-1:0] OPC_MOVE  = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OPC_FANF  = OPC_W'(4'h3);
  localparam logic [HDG_W-1:0] HDG_N     = HDG_W'(8'h00);
  localparam logic [HDG_W-1:0] HDG_W_    = HDG_W'(8'h3F);
  localparam logic [HDG_W-1:0] HDG_S     = HDG_W'(8'h7F);
  localparam logic [HDG_W-1:0] HDG_E     = HDG_W'(8'hBF);
  localparam logic [7:0]       RESP_DONE = 8'hA5;
  localparam logic [7:0]       RESP_BUSY = 8'h5A;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [HDG_W-1:0] heading;
    logic [SQ_W-1:0]  squares;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] mv_indx_nxt;
  logic [HDG_W-1:0] v_hdg, h_hdg;
  logic [SQ_W-1:0]  v_sq, h_sq;
  cmd_t             vert_cmd, horz_cmd;

  // Knight move -> vertical and horizontal legs; anything not one-hot is a null move.
  always_comb begin
    v_hdg = HDG_N;
    v_sq  = SQ_W'(0);
    h_hdg = HDG_N;
    h_sq  = SQ_W'(0);
    case (move)
      8'h01: begin v_hdg = HDG_N; v_sq = SQ_W'(2); h_hdg = HDG_W_; h_sq = SQ_W'(1); end
      8'h02: begin v_hdg = HDG_N; v_sq = SQ_W'(2); h_hdg = HDG_E;  h_sq = SQ_W'(1); end
      8'h04: begin v_hdg = HDG_N; v_sq = SQ_W'(1); h_hdg = HDG_W_; h_sq = SQ_W'(2); end
      8'h08: begin v_hdg = HDG_S; v_sq = SQ_W'(1); h_hdg = HDG_W_; h_sq = SQ_W'(2); end
      8'h10: begin v_hdg = HDG_S; v_sq = SQ_W'(2); h_hdg = HDG_W_; h_sq = SQ_W'(1); end
      8'h20: begin v_hdg = HDG_S; v_sq = SQ_W'(2); h_hdg = HDG_E;  h_sq = SQ_W'(1); end
      8'h40: begin v_hdg = HDG_S; v_sq = SQ_W'(1); h_hdg = HDG_E;  h_sq = SQ_W'(2); end
      8'h80: begin v_hdg = HDG_N; v_sq = SQ_W'(1); h_hdg = HDG_E;  h_sq = SQ_W'(2); end
      default: ;
    endcase
    vert_cmd = '{opcode: OPC_MOVE, heading: v_hdg, squares: v_sq};
    horz_cmd = '{opcode: OPC_FANF, heading: h_hdg, squares: h_sq};
  end

  // State and replay index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      state   <= state_nxt;
      mv_indx <= mv_indx_nxt;
    end
  end

  // Next state, index update and command/response muxing.
  always_comb begin
    state_nxt        = state;
    mv_indx_nxt      = mv_indx;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_BUSY;
    case (state)
      IDLE: begin
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (start_tour) begin
          mv_indx_nxt = '0;
          state_nxt   = VERT;
        end
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = WAIT_V;
      end
      WAIT_V: begin
        cmd = vert_cmd;
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        if (mv_indx == LAST_IDX) resp = RESP_DONE;
        if (send_resp) begin
          if (mv_indx == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            mv_indx_nxt = mv_indx + IDX_W'(1);
            state_nxt   = VERT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
